// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier with a shared tri-state operand/result bus.
// Optional signed (Booth radix-2) mode is enabled by defining SEQ_MULTIPLIER_SIGNED_EN.
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         start,
    input  logic [1:0]   func,
    input  logic         oe,
    input  logic         sgn,
    inout  wire  [N-1:0] data,
    output logic         ready,
    output logic         done
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_m;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_mw;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_wq;
    logic            r_qm1;
    logic            r_sgn;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_prod;
    logic            r_done;
    logic [N:0]      w_a_ext;
    logic [N:0]      w_addend;
    logic [N:0]      w_sum;
    logic [N-1:0]    w_a_nxt;
    logic [N-1:0]    w_q_nxt;
    logic            w_last;
    logic            w_unused_sgn;

    assign w_last       = (r_cnt == CW'(N - 1));
    assign w_a_nxt      = w_sum[N:1];
    assign w_q_nxt      = {w_sum[0], r_wq[N-1:1]};
    assign w_unused_sgn = r_sgn;

    // One iteration: choose the addend from the multiplier bit(s), form the N+1-bit sum.
    always_comb begin
        w_a_ext  = {1'b0, r_a};
        w_addend = {(N+1){1'b0}};
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        if (r_sgn) begin
            // A is sign-extended so the shifted sum stays exact even for -2^(N-1) * -2^(N-1).
            w_a_ext = {r_a[N-1], r_a};
            case ({r_wq[0], r_qm1})
                2'b01:   w_addend = {r_mw[N-1], r_mw};
                2'b10:   w_addend = ~{r_mw[N-1], r_mw} + {{N{1'b0}}, 1'b1};
                default: w_addend = {(N+1){1'b0}};
            endcase
        end else begin
            w_addend = r_wq[0] ? {1'b0, r_mw} : {(N+1){1'b0}};
        end
`else
        if (r_wq[0]) begin
            w_addend = {1'b0, r_mw};
        end else begin
            w_addend = {(N+1){1'b0}};
        end
`endif
        w_sum = w_a_ext + w_addend;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_nxt = w_last ? ST_IDLE : ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        ready = 1'b1;
        case (r_state)
            ST_IDLE: ready = 1'b1;
            ST_RUN:  ready = 1'b0;
            default: ready = 1'b1;
        endcase
    end

    // Operand registers, iteration datapath and product register.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            r_m    <= {N{1'b0}};
            r_q    <= {N{1'b0}};
            r_mw   <= {N{1'b0}};
            r_a    <= {N{1'b0}};
            r_wq   <= {N{1'b0}};
            r_qm1  <= 1'b0;
            r_sgn  <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_prod <= {(2*N){1'b0}};
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!oe && (func == 2'b00)) begin
                        r_m <= data;
                    end else if (!oe && (func == 2'b01)) begin
                        r_q <= data;
                    end
                    // Working copies take the pre-edge operands so a same-edge write cannot leak in.
                    if (start) begin
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                        r_sgn <= sgn;
`endif
                        r_mw  <= r_m;
                        r_a   <= {N{1'b0}};
                        r_wq  <= r_q;
                        r_qm1 <= 1'b0;
                        r_cnt <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    r_a   <= w_a_nxt;
                    r_wq  <= w_q_nxt;
                    r_qm1 <= r_wq[0];
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        r_prod <= {w_a_nxt, w_q_nxt};
                        r_done <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign done = r_done;
    assign data = (oe && func[1]) ? (func[0] ? r_prod[2*N-1:N] : r_prod[N-1:0]) : {N{1'bz}};

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: bus reads are queued with expected bytes and
// compared by an independent monitor; products come from plain integer arithmetic.
module tb_seq_multiplier;
    localparam int N = 8;

    logic         clock = 1'b0;
    logic         n_reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   func = 2'b10;
    logic         oe = 1'b0;
    logic         sgn = 1'b0;
    logic         tb_en = 1'b0;
    logic [N-1:0] tb_data = '0;
    wire  [N-1:0] data;
    logic         ready;
    logic         done;

    int n_vec = 0;
    int n_bad = 0;
    logic [N-1:0]   exp_q[$];
    logic [N-1:0]   model_m = '0;
    logic [N-1:0]   model_q = '0;
    logic [2*N-1:0] model_prod = '0;

    assign data = tb_en ? tb_data : {N{1'bz}};

    seq_multiplier #(.N(N)) dut (
        .clock(clock), .n_reset(n_reset), .start(start), .func(func), .oe(oe),
        .sgn(sgn), .data(data), .ready(ready), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle the block is asked to drive the bus, compare against the queue.
    always @(negedge clock) begin
        if (oe && func[1]) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL read_unexpected: got 0x%0h, expected no read", data);
            end else begin
                check("bus_read", 32'(data), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] m, input logic [N-1:0] q,
                                                input logic s);
        longint a;
        longint b;
        a = s ? longint'($signed(m)) : longint'(m);
        b = s ? longint'($signed(q)) : longint'(q);
        return (2*N)'(a * b);
    endfunction

    task automatic wr(input logic [1:0] f, input logic [N-1:0] v);
        oe = 1'b0; func = f; tb_en = 1'b1; tb_data = v;
        @(posedge clock); #1;
        tb_en = 1'b0; func = 2'b10;
        if (f == 2'b00) model_m = v; else model_q = v;
    endtask

    task automatic rd_both();
        oe = 1'b1; tb_en = 1'b0; func = 2'b10; exp_q.push_back(model_prod[N-1:0]);
        @(posedge clock); #1;
        func = 2'b11; exp_q.push_back(model_prod[2*N-1:N]);
        @(posedge clock); #1;
        oe = 1'b0; func = 2'b10;
    endtask

    // Launch a multiply; optionally a same-edge M write, or disturbance during RUN.
    task automatic run_mul(input logic s, input bit same_wr, input logic [N-1:0] wv,
                           input bit disturb);
        logic [2*N-1:0] exp_p;
        int cyc;
        bit fin;
        exp_p = ref_prod(model_m, model_q, s);
        sgn = s; start = 1'b1;
        if (same_wr) begin
            oe = 1'b0; func = 2'b00; tb_en = 1'b1; tb_data = wv;
        end
        @(posedge clock); #1;
        start = 1'b0; tb_en = 1'b0; func = 2'b10;
        if (same_wr) model_m = wv;
        cyc = 0; fin = 0;
        while (!fin && cyc < 100) begin
            if (disturb && cyc == 2) begin
                oe = 1'b1; func = 2'b10; tb_en = 1'b0; exp_q.push_back(model_prod[N-1:0]);
            end else if (disturb && cyc == 3) begin
                oe = 1'b0; func = 2'b00; tb_en = 1'b1; tb_data = 8'd99; start = 1'b1;
            end else begin
                oe = 1'b0; func = 2'b10; tb_en = 1'b0; start = 1'b0;
            end
            @(negedge clock);
            if (ready) fin = 1; else cyc++;
            if (!fin) begin @(posedge clock); #1; end
        end
        check("ready_low_cycles", 32'(cyc), 32'(N));
        check("done_pulse", 32'(done), 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        @(posedge clock); #1;
        model_prod = exp_p;
        rd_both();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        n_reset = 1'b1;
        rd_both();

        wr(2'b00, 8'd13); wr(2'b01, 8'd11);
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);
        check("p13x11", 32'(model_prod), 32'h008F);
        wr(2'b00, 8'd255); wr(2'b01, 8'd255);
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);
        check("p255x255", 32'(model_prod), 32'hFE01);
        wr(2'b00, 8'd0); wr(2'b01, 8'd200);
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);
        wr(2'b00, 8'd253); wr(2'b01, 8'd5);
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);
        check("p253x5", 32'(model_prod), 32'h04F1);

        // Writes and start during RUN are dropped; the next run still uses the old M.
        wr(2'b00, 8'd21); wr(2'b01, 8'd6);
        run_mul(1'b0, 1'b0, 8'd0, 1'b1);
        wr(2'b01, 8'd3);
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);

        // oe=1 with a write function: block must not drive the bus, and M is untouched.
        oe = 1'b1; func = 2'b00; tb_en = 1'b1; tb_data = 8'h3C;
        @(negedge clock);
        check("bus_not_driven", 32'(data), 32'h3C);
        @(posedge clock); #1;
        oe = 1'b0; tb_en = 1'b0; func = 2'b10;
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);

        // Same-edge write and start: multiply uses pre-edge M, write still lands.
        run_mul(1'b0, 1'b1, 8'd7, 1'b0);
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        wr(2'b00, 8'hFD); wr(2'b01, 8'd5);
        run_mul(1'b1, 1'b0, 8'd0, 1'b0);
        check("s_m3x5", 32'(model_prod), 32'hFFF1);
        wr(2'b00, 8'h80); wr(2'b01, 8'h80);
        run_mul(1'b1, 1'b0, 8'd0, 1'b0);
        check("s_m128sq", 32'(model_prod), 32'h4000);
`endif

        for (int i = 0; i < 20; i++) begin
            logic s;
            s = 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            sgn = 1'($urandom_range(0, 1));
`endif
            wr(2'b00, N'($urandom)); wr(2'b01, N'($urandom));
            run_mul(s, 1'b0, 8'd0, 1'b0);
        end

        // Reset in the middle of a run abandons it and clears the product.
        wr(2'b00, 8'd77); wr(2'b01, 8'd91);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        n_reset = 1'b0;
        @(posedge clock); #1;
        n_reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_ready", 32'(ready), 32'd1);
        check("midrun_reset_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        model_m = '0; model_q = '0; model_prod = '0;
        rd_both();
        run_mul(1'b0, 1'b0, 8'd0, 1'b0);

        @(posedge clock); #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL read_pending: got %0d outstanding reads, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port n_reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a multiply of the held operands.
REQ-005 SHALL have port func  input  2  bus function: 00 write M, 01 write Q, 10 read product low, 11 read product high.
REQ-006 SHALL have port oe  input  1  1 = block drives data, 0 = block samples data.
REQ-007 SHALL have port sgn  input  1  1 = signed operands (active only under the configuration macro).
REQ-008 SHALL have port data  inout  N  shared operand/result bus.
REQ-009 SHALL have port ready  output  1  1 = idle, accepts start and operand writes.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a new product is available.

Function
REQ-011 SHALL implement two states: IDLE (ready=1) and RUN (ready=0); no other states.
REQ-012 SHALL, in IDLE with oe=0, load M from data on a clock edge when func=00, and Q when func=01; func 10/11 with oe=0 SHALL load nothing.
REQ-013 SHALL ignore operand writes while in RUN; M and Q keep their values.
REQ-014 SHALL, in IDLE on an edge with start=1, latch sgn, load accumulator A=0, AQ low half=Q, counter=0, and enter RUN.
REQ-015 SHALL, when start and an operand write share an edge, use the pre-edge M/Q for the multiply; the write still completes.
REQ-016 SHALL perform one iteration per RUN cycle; unsigned: if AQ[0]=1, {C,A}=A+M (N+1-bit sum); then {C,A,Q} shifts right one place.
REQ-017 SHALL complete after exactly N RUN cycles: ready is low for exactly N cycles, then returns to 1 on the edge that copies the 2N-bit AQ into the product register.
REQ-018 SHALL assert done for exactly the one cycle following the product-register update.
REQ-019 SHALL ignore start while in RUN; start held high across completion SHALL launch a new multiply on the first IDLE edge.
REQ-020 SHALL hold the product register unchanged during RUN; reads return the previous product until completion.
REQ-021 SHALL drive data with product[N-1:0] when oe=1 and func=10, product[2N-1:N] when oe=1 and func=11, and high-Z in all other cases, including oe=1 with func 00/01.
REQ-022 SHALL produce the exact 2N-bit product with no truncation or overflow flag; 0 in either operand yields 0.

Reset
REQ-023 SHALL, on an edge with n_reset=0, enter IDLE and clear M, Q, A, counter, product register and latched sgn, with ready=1 and done=0, regardless of current state.
REQ-024 SHALL abandon any RUN in progress on reset; the product register SHALL read 0 after reset.
REQ-025 SHALL give reset priority over start and operand writes in the same cycle.

Configuration
REQ-026 SHALL support macro SEQ_MULTIPLIER_SIGNED_EN.
REQ-027 SHALL, with SEQ_MULTIPLIER_SIGNED_EN defined and latched sgn=1, use radix-2 Booth recoding with an extra Q[-1] bit (cleared at start): pair 01 adds M, pair 10 subtracts M, then arithmetic right shift of {A,Q,Q[-1]}; the result is the two's-complement 2N-bit product, latency unchanged.
REQ-028 SHALL, with the macro defined and latched sgn=0, behave exactly as the unsigned path.
REQ-029 SHALL, without the macro, ignore sgn, omit the Booth logic and perform only unsigned multiplication.

Verification
REQ-030 SHALL check: n_reset=0 for one edge mid-RUN -> next cycle ready=1, done=0, reads of 10/11 return 0x00/0x00.
REQ-031 SHALL check (N=8): M=13, Q=11, start pulse -> ready low exactly 8 cycles, done pulse, read 10=0x8F, 11=0x00.
REQ-032 SHALL check (N=8): M=255, Q=255 -> product 0xFE01; M=0, Q=200 -> 0x0000.
REQ-033 SHALL check: during RUN, write M=99 and pulse start -> both ignored, product matches the original operands, M still reads back its old effect on the next multiply.
REQ-034 SHALL check: reads during RUN return the prior product; oe=1 with func=00 -> data high-Z, M unchanged.
REQ-035 SHALL check (macro defined, N=8, sgn=1): -3*5 -> 0xFFF1; -128*-128 -> 0x4000; with sgn=0, 253*5 -> 0x04F1.
